// File: rtl/xcvr_8b10b_link_ctrl_if.sv
// Link-controller signal bundle: the controller side uses the master modport
// (ready/sync status in, reset/align/status out), the transceiver side uses slave.
interface xcvr_8b10b_link_ctrl_if #(
  parameter int NUM_LANES = 4
);
  logic                      enable;
  logic [NUM_LANES-1:0]      tx_ready;
  logic [NUM_LANES-1:0]      rx_ready;
  logic [2*NUM_LANES-1:0]    rx_syncstatus;
  logic                      xcvr_rst_req;
  logic [NUM_LANES-1:0]      rx_patternalign;
  logic                      link_up;
  logic [NUM_LANES-1:0]      lane_synced;
  logic [2:0]                state;
  logic [7:0]                retry_cnt;
  logic [16*NUM_LANES-1:0]   sync_loss_cnt;

  modport master (
    input  enable, tx_ready, rx_ready, rx_syncstatus,
    output xcvr_rst_req, rx_patternalign, link_up, lane_synced,
           state, retry_cnt, sync_loss_cnt
  );

  modport slave (
    output enable, tx_ready, rx_ready, rx_syncstatus,
    input  xcvr_rst_req, rx_patternalign, link_up, lane_synced,
           state, retry_cnt, sync_loss_cnt
  );
endinterface

// File: rtl/xcvr_8b10b_link_ctrl.sv
// Bring-up / supervision FSM for an N-lane 8B/10B transceiver: drives the reset
// controller, pulses manual word alignment, qualifies sync lock, and recovers
// from ready/sync loss with a bounded align retry before a full reset.
// Optional per-lane sync-loss counters: define XCVR_LINK_ERRCNT_EN.
module xcvr_8b10b_link_ctrl #(
  parameter int NUM_LANES       = 4,
  parameter int RST_CYCLES      = 64,
  parameter int READY_TIMEOUT   = 50000,
  parameter int ALIGN_PULSE     = 4,
  parameter int LOCK_CYCLES     = 1024,
  parameter int ALIGN_TIMEOUT   = 20000,
  parameter int MAX_ALIGN_TRIES = 3,
  parameter int DROP_TOL        = 8
) (
  input logic                    clk_clk,
  input logic                    reset_reset,
  xcvr_8b10b_link_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_ALIGN      = 3'd2,
    ST_CHECK      = 3'd3,
    ST_UP         = 3'd4
  } state_t;

  // Terminal values: "N cycles in a state" ends on the cycle the counter shows N-1.
  localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] READY_LAST = 16'(READY_TIMEOUT - 1);
  localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_PULSE - 1);
  localparam logic [15:0] LOCK_LAST  = 16'(LOCK_CYCLES - 1);
  localparam logic [15:0] ATO_LAST   = 16'(ALIGN_TIMEOUT - 1);
  localparam logic [7:0]  DROP_LAST  = 8'(DROP_TOL - 1);
  localparam logic [3:0]  MAX_TRIES  = 4'(MAX_ALIGN_TRIES);

  state_t                 state_q, state_nxt;
  logic [NUM_LANES-1:0]   tx_meta, tx_sync, rx_meta, rx_sync;
  logic [2*NUM_LANES-1:0] ss_meta, ss_sync;
  logic [NUM_LANES-1:0]   lane_synced_q, lane_synced_nxt;
  logic [15:0]            timer_q, lock_cnt_q;
  logic [7:0]             drop_cnt_q, retry_q;
  logic [3:0]             try_q;
  logic                   ready_all, all_synced, escalate;
  logic                   rst_req_q, rst_req_nxt, align_q, align_nxt, link_up_q, link_up_nxt;

  // Two-flop synchronizers for the asynchronous status inputs, plus the lane_synced register.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      tx_meta       <= '0;
      tx_sync       <= '0;
      rx_meta       <= '0;
      rx_sync       <= '0;
      ss_meta       <= '0;
      ss_sync       <= '0;
      lane_synced_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
      tx_meta       <= bus.tx_ready;
      tx_sync       <= tx_meta;
      rx_meta       <= bus.rx_ready;
      rx_sync       <= rx_meta;
      ss_meta       <= bus.rx_syncstatus;
      ss_sync       <= ss_meta;
      lane_synced_q <= lane_synced_nxt;
    end
  end

  // Per-lane lock: both byte aligners of the lane report sync.
  always_comb begin
    // NOTE: default first so no path leaves the signal unassigned (no latch).
    lane_synced_nxt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_synced_nxt[i] = &ss_sync[2*i +: 2];
    end
  end

  assign ready_all  = (&tx_sync) & (&rx_sync);
  assign all_synced = &lane_synced_q;

  // State register and registered outputs, so outputs change together with state.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q   <= ST_RESET;
      rst_req_q <= 1'b1;
      align_q   <= 1'b0;
      link_up_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      rst_req_q <= rst_req_nxt;
      align_q   <= align_nxt;
      link_up_q <= link_up_nxt;
    end
  end

  // Next-state logic; later assignments override earlier ones to encode priority.
  always_comb begin
    state_nxt = state_q;
    escalate  = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (bus.enable && timer_q >= RST_LAST) state_nxt = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        if (ready_all) begin
          state_nxt = ST_ALIGN;
        end else if (timer_q == READY_LAST) begin
          state_nxt = ST_RESET;
          escalate  = 1'b1;
        end
      end
      ST_ALIGN: begin
        if (timer_q == ALIGN_LAST) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (all_synced && lock_cnt_q == LOCK_LAST) begin
          state_nxt = ST_UP;
        end else if (timer_q == ATO_LAST) begin
          if (try_q < MAX_TRIES) begin
            state_nxt = ST_ALIGN;
          end else begin
            state_nxt = ST_RESET;
            escalate  = 1'b1;
          end
        end
      end
      ST_UP: begin
        if (!all_synced && drop_cnt_q == DROP_LAST) state_nxt = ST_ALIGN;
      end
      default: state_nxt = ST_RESET;
    endcase
    // Ready loss once the link was ready; WAIT_READY is excluded because low
    // readies are its normal condition and are handled by its own timeout.
    if ((state_q == ST_ALIGN || state_q == ST_CHECK || state_q == ST_UP) && !ready_all) begin
      state_nxt = ST_RESET;
      escalate  = 1'b1;
    end
    // Disable is a deliberate stop, not a failure, so it is not counted.
    if (!bus.enable) begin
      state_nxt = ST_RESET;
      escalate  = 1'b0;
    end
  end

  // Output decode from the next state, registered above.
  always_comb begin
    rst_req_nxt = (state_nxt == ST_RESET);
    align_nxt   = (state_nxt == ST_ALIGN);
    link_up_nxt = (state_nxt == ST_UP);
  end

  // Shared state timer, lock/drop counters, align try count and escalation count.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      timer_q    <= '0;
      lock_cnt_q <= '0;
      drop_cnt_q <= '0;
      try_q      <= '0;
      retry_q    <= '0;
    end else begin
      if (state_nxt != state_q)    timer_q <= '0;
      else if (timer_q != 16'hFFFF) timer_q <= timer_q + 16'd1;

      lock_cnt_q <= (state_q == ST_CHECK && all_synced)  ? lock_cnt_q + 16'd1 : '0;
      drop_cnt_q <= (state_q == ST_UP    && !all_synced) ? drop_cnt_q + 8'd1  : '0;

      if (state_q == ST_RESET || (state_nxt == ST_UP && state_q != ST_UP))
        try_q <= '0;
      else if (state_nxt == ST_ALIGN && state_q != ST_ALIGN)
        try_q <= try_q + 4'd1;

      if (escalate && retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
    end
  end

  assign bus.xcvr_rst_req    = rst_req_q;
  assign bus.rx_patternalign = {NUM_LANES{align_q}};
  assign bus.link_up         = link_up_q;
  assign bus.lane_synced     = lane_synced_q;
  assign bus.state           = state_q;
  assign bus.retry_cnt       = retry_q;

`ifdef XCVR_LINK_ERRCNT_EN
  logic [16*NUM_LANES-1:0] loss_q;

  // Count each lane's falling lock edge while the link is up; saturating.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      loss_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (state_q == ST_UP && lane_synced_q[i] && !lane_synced_nxt[i] &&
            loss_q[16*i +: 16] != 16'hFFFF)
          loss_q[16*i +: 16] <= loss_q[16*i +: 16] + 16'd1;
      end
    end
  end

  assign bus.sync_loss_cnt = loss_q;
`else
  assign bus.sync_loss_cnt = '0;
`endif

endmodule
